// File: rtl/msg_schedule.sv
// SHA-256 message-schedule expander: loads 16 words, then streams W[0..63].
// A 16-word sliding window computes each new word from the taps at 0, 1, 9 and 14.
module msg_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [5:0]  out_idx,
  output logic        out_last
);

  typedef enum logic {LOAD, EXPAND} state_t;

  state_t      state, state_nxt;
  logic [31:0] w [16];
  logic [3:0]  load_cnt;
  logic [5:0]  out_cnt;
  logic        in_hs, out_hs;
  logic [31:0] w_new;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign w_new = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    in_hs     = 1'b0;
    out_hs    = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        in_hs    = in_valid;
        if (in_valid && load_cnt == 4'd15) state_nxt = EXPAND;
      end
      EXPAND: begin
        out_valid = 1'b1;
        out_hs    = out_ready;
        if (out_ready && out_cnt == 6'd63) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Loading and expanding share one shift path; only the word entering slot 15 differs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (in_hs || out_hs) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= in_hs ? in_word : w_new;
    end
  end

  // Both counters wrap naturally back to zero at the end of their phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt <= '0;
      out_cnt  <= '0;
    end else begin
      if (in_hs)  load_cnt <= load_cnt + 4'd1;
      if (out_hs) out_cnt  <= out_cnt + 6'd1;
    end
  end

  assign out_word = out_valid ? w[0] : 32'd0;
  assign out_idx  = out_cnt;
  assign out_last = out_valid && (out_cnt == 6'd63);

endmodule

// File: tb/tb_msg_schedule.sv
// Randomized scoreboard bench for msg_schedule against a plain-arithmetic SHA-256 schedule model.
module tb_msg_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [5:0]  out_idx;
  logic        out_last;

  msg_schedule dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] got [64];
  int          in_cnt = 0;
  bit          pend_exp = 0;
  bit          pend_back = 0;
  int          rmode = 0;
  int          stall_left = 0;
  bit          stalled_once = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return {x, x} >> n;
  endfunction

  // Reference schedule straight from the FIPS 180-4 recurrence.
  function automatic void schedule(input logic [31:0] m [16], output logic [31:0] ws [64]);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) ws[t] = m[t];
      else ws[t] = (rr(ws[t-2], 17) ^ rr(ws[t-2], 19) ^ (ws[t-2] >> 10)) + ws[t-7]
                 + (rr(ws[t-15], 7) ^ rr(ws[t-15], 18) ^ (ws[t-15] >> 3)) + ws[t-16];
    end
  endfunction

  // Monitor: compares every presented output (stalled or not) to the queue head.
  always @(negedge clk) begin
    if (rst) begin
      in_cnt = 0; pend_exp = 0; pend_back = 0;
    end else begin
      if (pend_exp) chk("latency_out_valid", {63'd0, out_valid}, 64'd1);
      pend_exp = 0;
      if (pend_back) chk("reload_ready_valid", {62'd0, in_ready, out_valid}, 64'd2);
      pend_back = 0;
      if (in_valid) chk("no_overlap", {63'd0, in_ready && out_valid}, 64'd0);
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_output", {58'd0, out_idx}, 64'hFFFF);
        else begin
          chk("out_word", {32'd0, out_word}, {32'd0, q[0].word});
          chk("out_idx_last", {57'd0, out_idx, out_last}, {57'd0, q[0].idx, q[0].last});
          if (out_ready) begin
            got[out_idx] = out_word;
            if (out_last) pend_back = 1;
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        in_cnt++;
        if (in_cnt == 16) begin pend_exp = 1; in_cnt = 0; end
      end
    end
  end

  // out_ready driver: mode 0 always ready; mode 1 stalls 5 cycles at idx 20, then random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rmode == 0) out_ready = 1'b1;
      else begin
        if (out_valid && out_idx == 6'd20 && !stalled_once) begin
          stall_left = 5; stalled_once = 1;
        end
        if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
        else out_ready = stalled_once ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  task automatic load_words(input logic [31:0] m [16], input bit gaps, input bit hold);
    logic [31:0] ws [64];
    bit ok;
    int tries;
    schedule(m, ws);
    for (int t = 0; t < 64; t++) q.push_back('{ws[t], 6'(t), t == 63});
    for (int t = 0; t < 64; t++) got[t] = 32'hDEADBEEF;
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_word  = m[i];
      tries = 0;
      do begin
        @(negedge clk); ok = in_ready;
        @(posedge clk); #1; tries++;
      end while (!ok && tries < 50);
      if (!ok) chk("load_timeout", 64'd0, 64'd1);
    end
    if (hold) in_word = $urandom;
    else in_valid = 1'b0;
  endtask

  task automatic wait_last();
    int n = 0;
    @(negedge clk);
    while (!(out_valid && out_last && out_ready) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("last_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic check_abc_spots();
    chk("abc_w0", {32'd0, got[0]}, 64'h61626380);
    chk("abc_w15", {32'd0, got[15]}, 64'h00000018);
    chk("abc_w16", {32'd0, got[16]}, 64'h61626380);
    chk("abc_w17", {32'd0, got[17]}, 64'h000F0000);
    chk("abc_w18", {32'd0, got[18]}, 64'h7DA86405);
    chk("abc_w19", {32'd0, got[19]}, 64'h600003C6);
    chk("abc_w63", {32'd0, got[63]}, 64'h12B1EDEB);
  endtask

  logic [31:0] abc [16];
  logic [31:0] imp [16];
  logic [31:0] zro [16];

  initial begin
    for (int i = 0; i < 16; i++) begin abc[i] = 0; imp[i] = 0; zro[i] = 0; end
    abc[0] = 32'h61626380; abc[15] = 32'h00000018; imp[0] = 32'd1;
    rst = 1'b1; in_valid = 1'b0; in_word = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_outs", {25'd0, out_valid, out_word, out_idx, out_last}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    load_words(abc, 0, 0); wait_last(); drain(); check_abc_spots();

    load_words(imp, 0, 0); wait_last(); drain();
    chk("imp_w16", {32'd0, got[16]}, 64'h1);
    chk("imp_w17", {32'd0, got[17]}, 64'h0);
    chk("imp_w18", {32'd0, got[18]}, 64'h0000A000);
    chk("imp_w19", {32'd0, got[19]}, 64'h0);

    load_words(zro, 0, 0); wait_last();
    chk("zero_w63", {32'd0, got[63]}, 64'h0);
    load_words(abc, 0, 0); wait_last(); drain(); check_abc_spots();

    rmode = 1;
    load_words(abc, 0, 1); wait_last(); drain(); check_abc_spots();
    rmode = 0;

    load_words(abc, 1, 0); wait_last(); drain(); check_abc_spots();

    for (int b = 0; b < 3; b++) begin
      logic [31:0] rnd [16];
      for (int i = 0; i < 16; i++) rnd[i] = $urandom;
      load_words(rnd, 1, 0); wait_last(); drain();
    end

    load_words(abc, 0, 0);
    begin
      int n = 0;
      @(negedge clk);
      while (!(out_valid && out_idx == 6'd30) && n < 200) begin @(negedge clk); n++; end
      chk("reach_idx30", {63'd0, n < 200}, 64'd1);
    end
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_outs", {25'd0, out_valid, out_word, out_idx, out_last}, 64'd0);
    q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    load_words(abc, 0, 0); wait_last(); drain(); check_abc_spots();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
